change_dispenser: RTL

- Sequences payout of `change_due` from `fsm_controller` into individual coin requests for a three-tube coin hopper (denominations 5, 2, 1).
- Uses greedy largest-first selection, skipping empty tubes.
- Issues one coin request at a time using a request/ack handshake, with an ack timeout and an inter-coin gap.
- Sits between `fsm_controller` (start/amount) and the hopper drive pins; status outputs feed `led_feedback` and `display_driver`.

---
 rtl/change_dispenser.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// Greedy 5/2/1 change payout sequencer driving a three-tube coin hopper with a request/ack handshake.
// Optional per-denomination coin logging is enabled by defining DISPENSE_LOG_EN.
module change_dispenser #(
    parameter int ACK_TIMEOUT = 1000000,
    parameter int GAP_CYCLES  = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       abort,
    input  logic       clear_fault,
    input  logic [2:0] hopper_empty,
    input  logic       hopper_ack,
    output logic [2:0] coin_req,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [7:0] remaining,
    output logic [7:0] count5,
    output logic [7:0] count2,
    output logic [7:0] count1
);

    localparam int TMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_REQUEST,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_next;
    logic [7:0]      r_remaining;
    logic [7:0]      w_remaining_next;
    logic [2:0]      r_coin_req;
    logic [2:0]      w_coin_req_next;
    logic            r_busy;
    logic            w_busy_next;
    logic            r_done;
    logic            w_done_next;
    logic            r_fault;
    logic            w_fault_next;
    logic [2:0]      w_eligible;
    logic [2:0]      w_pick;
    logic [7:0]      w_req_value;

    function automatic logic [7:0] f_denom(input int idx);
        case (idx)
            2:       f_denom = 8'd5;
            1:       f_denom = 8'd2;
            default: f_denom = 8'd1;
        endcase
    endfunction

    function automatic logic [7:0] f_value(input logic [2:0] onehot);
        case (onehot)
            3'b100:  f_value = 8'd5;
            3'b010:  f_value = 8'd2;
            3'b001:  f_value = 8'd1;
            default: f_value = 8'd0;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_elig
            assign w_eligible[gi] = !hopper_empty[gi] && (r_remaining >= f_denom(gi));
        end
    endgenerate

    // Largest eligible denomination wins; bit 2 (the 5-tube) has top priority.
    always_comb begin
        w_pick = 3'b000;
        if (w_eligible[2])
            w_pick = 3'b100;
        else if (w_eligible[1])
            w_pick = 3'b010;
        else if (w_eligible[0])
            w_pick = 3'b001;
    end

    assign w_req_value = f_value(r_coin_req);

    always_comb begin
        w_state_next     = r_state;
        w_timer_next     = r_timer;
        w_remaining_next = r_remaining;
        w_coin_req_next  = 3'b000;
        w_done_next      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_timer_next = '0;
                if (start) begin
                    w_remaining_next = amount;
                    w_state_next     = S_SELECT;
                end
            end
            S_SELECT: begin
                w_timer_next = '0;
                if (abort)
                    w_state_next = S_IDLE;
                else if (r_remaining == 8'd0)
                    w_state_next = S_DONE;
                else if (w_pick != 3'b000) begin
                    w_state_next    = S_REQUEST;
                    w_coin_req_next = w_pick;
                end else
                    w_state_next = S_FAULT;
            end
            S_REQUEST: begin
                // An ack in the same cycle as abort is still credited.
                if (hopper_ack) begin
                    if (w_req_value <= r_remaining)
                        w_remaining_next = r_remaining - w_req_value;
                    w_timer_next = '0;
                    w_state_next = abort ? S_IDLE : S_GAP;
                end else if (abort) begin
                    w_timer_next = '0;
                    w_state_next = S_IDLE;
                end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
                    w_timer_next = '0;
                    w_state_next = S_FAULT;
                end else begin
                    w_timer_next    = r_timer + 1'b1;
                    w_coin_req_next = r_coin_req;
                end
            end
            S_GAP: begin
                if (abort) begin
                    w_timer_next = '0;
                    w_state_next = S_IDLE;
                end else if (r_timer == TW'(GAP_CYCLES - 1)) begin
                    w_timer_next = '0;
                    w_state_next = S_SELECT;
                end else
                    w_timer_next = r_timer + 1'b1;
            end
            S_DONE: begin
                w_done_next  = 1'b1;
                w_state_next = S_IDLE;
            end
            S_FAULT: begin
                w_timer_next = '0;
                if (clear_fault)
                    w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_timer_next = '0;
            end
        endcase
        w_busy_next  = (w_state_next != S_IDLE) && (w_state_next != S_FAULT);
        w_fault_next = (w_state_next == S_FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_remaining <= 8'd0;
            r_coin_req  <= 3'b000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_timer     <= w_timer_next;
            r_remaining <= w_remaining_next;
            r_coin_req  <= w_coin_req_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_fault     <= w_fault_next;
        end
    end

    assign coin_req  = r_coin_req;
    assign busy      = r_busy;
    assign done      = r_done;
    assign fault     = r_fault;
    assign remaining = r_remaining;

`ifdef DISPENSE_LOG_EN
    logic w_start_accept;
    logic w_ack_coin;

    assign w_start_accept = (r_state == S_IDLE) && start;
    assign w_ack_coin     = (r_state == S_REQUEST) && hopper_ack;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_count
            logic [7:0] r_cnt;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_cnt <= 8'd0;
                else if (w_start_accept)
                    r_cnt <= 8'd0;
                else if (w_ack_coin && r_coin_req[gi] && (r_cnt != 8'hFF))
                    r_cnt <= r_cnt + 8'd1;
            end
        end
    endgenerate

    assign count1 = g_count[0].r_cnt;
    assign count2 = g_count[1].r_cnt;
    assign count5 = g_count[2].r_cnt;
`else
    assign count5 = 8'd0;
    assign count2 = 8'd0;
    assign count1 = 8'd0;
`endif

endmodule
